// File: rtl/urv_writeback_pkg.sv
// Shared load funct3 encodings and load-data alignment
// for the uRV writeback stage.
package urv_writeback_pkg;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;

    function automatic logic [31:0] load_align(
        input logic [2:0]  fun,
        input logic [1:0]  addr,
        input logic [31:0] data
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = data[{addr, 3'b000} +: 8];
        h = addr[1] ? data[31:16] : data[15:0];
        case (fun)
            FUNCT3_LB:  return {{24{b[7]}}, b};
            FUNCT3_LH:  return {{16{h[15]}}, h};
            FUNCT3_LBU: return {24'h0, b};
            FUNCT3_LHU: return {16'h0, h};
            default:    return data;
        endcase
    endfunction

endpackage

// File: rtl/urv_ecc.sv
// Check-bit generator: bits 5:0 are Hamming syndromes over data
// positions 1..32, bit 6 is overall data parity.
module urv_ecc (
    input  logic [31:0] data_i,
    output logic [6:0]  ecc_o
);

    always_comb begin
        ecc_o = '0;
        for (int j = 0; j < 32; j++) begin
            if (data_i[j])
                ecc_o = ecc_o ^ {1'b1, 6'(j + 1)};
        end
    end

endmodule

// File: rtl/urv_writeback.sv
// uRV writeback stage: retires execute ops, waits for load data,
// aligns it and drives the register file write port and bypass.
module urv_writeback
    import urv_writeback_pkg::*;
#(
    parameter int g_with_ecc = 0
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        x_valid_i,
    input  logic        x_load_i,
    input  logic        x_rd_write_i,
    input  logic [4:0]  x_rd_i,
    input  logic [31:0] x_rd_value_i,
    input  logic [2:0]  x_fun_i,
    input  logic [1:0]  x_dm_addr_i,
    input  logic        dm_load_done_i,
    input  logic [31:0] dm_data_l_i,
    output logic        w_stall_o,
    output logic        w_retire_o,
    output logic [4:0]  rf_rd_o,
    output logic [31:0] rf_rd_value_o,
    output logic [6:0]  rf_rd_ecc_o,
    output logic        rf_rd_store_o,
    output logic        rf_bypass_rd_write_o,
    output logic [31:0] rf_bypass_rd_value_o
);

    typedef enum logic {ST_IDLE, ST_LOAD_WAIT} state_t;

    state_t      state_q, state_d;
    logic [4:0]  ld_rd_q;
    logic        ld_write_q;
    logic [2:0]  ld_fun_q;
    logic [1:0]  ld_addr_q;
    logic        pend_q, pend_store_q;
    logic [4:0]  pend_rd_q;
    logic [31:0] pend_value_q;
    logic        load_done, accept, alu_acc, pend_d;
    logic        wr_en, wr_store;
    logic [4:0]  wr_rd;
    logic [31:0] wr_value;
    logic [6:0]  ecc_d;
    logic        store_q, retire_q;
    logic [4:0]  rd_q;
    logic [31:0] value_q;
    logic [6:0]  ecc_q;

    assign load_done = (state_q == ST_LOAD_WAIT) && dm_load_done_i;
    assign w_stall_o = (state_q == ST_LOAD_WAIT) && !dm_load_done_i;
    assign accept    = x_valid_i && !w_stall_o;
    assign alu_acc   = accept && !x_load_i;
    // An ALU op accepted on the load-done edge (or behind such an op)
    // is parked one cycle so neither write is lost.
    assign pend_d    = alu_acc && (load_done || pend_q);

    always_comb begin
        state_d  = state_q;
        wr_en    = 1'b0;
        wr_store = 1'b0;
        wr_rd    = rd_q;
        wr_value = value_q;
        if (accept && x_load_i)
            state_d = ST_LOAD_WAIT;
        else if (load_done)
            state_d = ST_IDLE;
        unique case (1'b1)
            load_done: begin
                wr_en    = 1'b1;
                wr_store = ld_write_q && (ld_rd_q != 5'd0);
                wr_rd    = ld_rd_q;
                wr_value = load_align(ld_fun_q, ld_addr_q, dm_data_l_i);
            end
            pend_q: begin
                wr_en    = 1'b1;
                wr_store = pend_store_q;
                wr_rd    = pend_rd_q;
                wr_value = pend_value_q;
            end
            (alu_acc && !pend_q && !load_done): begin
                wr_en    = 1'b1;
                wr_store = x_rd_write_i && (x_rd_i != 5'd0);
                wr_rd    = x_rd_i;
                wr_value = x_rd_value_i;
            end
            default: ;
        endcase
    end

    generate
        if (g_with_ecc != 0) begin : g_ecc
            urv_ecc u_ecc (
                .data_i (wr_value),
                .ecc_o  (ecc_d)
            );
        end else begin : g_no_ecc
            assign ecc_d = 7'd0;
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q  <= ST_IDLE;
            pend_q   <= 1'b0;
            store_q  <= 1'b0;
            retire_q <= 1'b0;
            rd_q     <= 5'd0;
            value_q  <= 32'd0;
            ecc_q    <= 7'd0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            store_q  <= wr_store;
            retire_q <= wr_en;
            if (wr_en) begin
                rd_q    <= wr_rd;
                value_q <= wr_value;
                ecc_q   <= ecc_d;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept && x_load_i) begin
            ld_rd_q    <= x_rd_i;
            ld_write_q <= x_rd_write_i;
            ld_fun_q   <= x_fun_i;
            ld_addr_q  <= x_dm_addr_i;
        end
        if (pend_d) begin
            pend_rd_q    <= x_rd_i;
            pend_store_q <= x_rd_write_i && (x_rd_i != 5'd0);
            pend_value_q <= x_rd_value_i;
        end
    end

    assign w_retire_o           = retire_q;
    assign rf_rd_o              = rd_q;
    assign rf_rd_value_o        = value_q;
    assign rf_rd_ecc_o          = ecc_q;
    assign rf_rd_store_o        = store_q;
    assign rf_bypass_rd_write_o = store_q;
    assign rf_bypass_rd_value_o = value_q;

endmodule

// File: tb/tb_urv_writeback.sv
// Directed testbench for urv_writeback with ECC enabled.
module tb_urv_writeback;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        x_valid, x_load, x_rd_write;
    logic [4:0]  x_rd;
    logic [31:0] x_rd_value;
    logic [2:0]  x_fun;
    logic [1:0]  x_dm_addr;
    logic        dm_done;
    logic [31:0] dm_data;
    logic        w_stall, w_retire, rf_store, byp_write;
    logic [4:0]  rf_rd;
    logic [31:0] rf_value, byp_value;
    logic [6:0]  rf_ecc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    urv_writeback #(.g_with_ecc(1)) dut (
        .clk_i                (clk),
        .rst_n_i              (rst_n),
        .x_valid_i            (x_valid),
        .x_load_i             (x_load),
        .x_rd_write_i         (x_rd_write),
        .x_rd_i               (x_rd),
        .x_rd_value_i         (x_rd_value),
        .x_fun_i              (x_fun),
        .x_dm_addr_i          (x_dm_addr),
        .dm_load_done_i       (dm_done),
        .dm_data_l_i          (dm_data),
        .w_stall_o            (w_stall),
        .w_retire_o           (w_retire),
        .rf_rd_o              (rf_rd),
        .rf_rd_value_o        (rf_value),
        .rf_rd_ecc_o          (rf_ecc),
        .rf_rd_store_o        (rf_store),
        .rf_bypass_rd_write_o (byp_write),
        .rf_bypass_rd_value_o (byp_value)
    );

    // Reference check bits: per-check-bit parity over data positions.
    function automatic logic [6:0] ecc_ref(input logic [31:0] d);
        logic [6:0] e;
        int p;
        e = '0;
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 32; j++) begin
                p = j + 1;
                if (((p >> i) & 1) == 1)
                    e[i] = e[i] ^ d[j];
            end
        end
        e[6] = ^d;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        x_valid    = 1'b0;
        x_load     = 1'b0;
        x_rd_write = 1'b0;
        dm_done    = 1'b0;
    endtask

    task automatic issue(input logic ld, input logic wr, input logic [4:0] rd,
                         input logic [31:0] v, input logic [2:0] fun,
                         input logic [1:0] addr);
        x_valid    = 1'b1;
        x_load     = ld;
        x_rd_write = wr;
        x_rd       = rd;
        x_rd_value = v;
        x_fun      = fun;
        x_dm_addr  = addr;
    endtask

    task automatic chk_wr(input string tag, input logic [4:0] rd,
                          input logic [31:0] v);
        chk({tag, "_store"}, {31'd0, rf_store}, 32'd1);
        chk({tag, "_retire"}, {31'd0, w_retire}, 32'd1);
        chk({tag, "_rd"}, {27'd0, rf_rd}, {27'd0, rd});
        chk({tag, "_value"}, rf_value, v);
        chk({tag, "_ecc"}, {25'd0, rf_ecc}, {25'd0, ecc_ref(v)});
        chk({tag, "_byp_wr"}, {31'd0, byp_write}, 32'd1);
        chk({tag, "_byp_val"}, byp_value, v);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_store"}, {31'd0, rf_store}, 32'd0);
        chk({tag, "_retire"}, {31'd0, w_retire}, 32'd0);
        chk({tag, "_byp_wr"}, {31'd0, byp_write}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        x_rd = '0; x_rd_value = '0; x_fun = '0; x_dm_addr = '0; dm_data = '0;
        for (int i = 0; i < 3; i++) begin
            x_valid    = 1'($urandom);
            x_load     = 1'($urandom);
            x_rd_write = 1'($urandom);
            x_rd       = 5'($urandom);
            x_rd_value = $urandom;
            x_fun      = 3'($urandom);
            x_dm_addr  = 2'($urandom);
            dm_done    = 1'($urandom);
            dm_data    = $urandom;
            step();
        end
        idle_in();
        #1;
        chk_quiet("rst");
        chk("rst_stall", {31'd0, w_stall}, 32'd0);
        chk("rst_rd", {27'd0, rf_rd}, 32'd0);
        chk("rst_value", rf_value, 32'd0);
        chk("rst_ecc", {25'd0, rf_ecc}, 32'd0);
        chk("rst_byp_val", byp_value, 32'd0);
        rst_n = 1'b1;
        step();

        // ALU op, latency 1
        issue(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 3'b000, 2'd0);
        step();
        idle_in();
        chk_wr("alu", 5'd5, 32'hDEADBEEF);
        step();
        chk_quiet("alu_after");

        // LB with done three cycles after accept
        issue(1'b1, 1'b1, 5'd7, 32'h0, 3'b000, 2'd3);
        step();
        idle_in();
        chk_quiet("lb_wait");
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("lb_stall", {31'd0, w_stall}, 32'd1);
            step();
        end
        dm_done = 1'b1;
        dm_data = 32'h80FF1234;
        #1;
        chk("lb_stall_done", {31'd0, w_stall}, 32'd0);
        step();
        idle_in();
        chk_wr("lb", 5'd7, 32'hFFFFFF80);
        step();
        chk_quiet("lb_after");

        // LHU then LH at addr 2, done in first wait cycle
        issue(1'b1, 1'b1, 5'd9, 32'h0, 3'b101, 2'd2);
        step();
        idle_in();
        dm_done = 1'b1;
        dm_data = 32'h80010000;
        step();
        idle_in();
        chk_wr("lhu", 5'd9, 32'h00008001);
        issue(1'b1, 1'b1, 5'd10, 32'h0, 3'b001, 2'd2);
        step();
        idle_in();
        dm_done = 1'b1;
        step();
        idle_in();
        chk_wr("lh", 5'd10, 32'hFFFF8001);
        step();

        // rd=0 write suppressed, retire still pulses
        issue(1'b0, 1'b1, 5'd0, 32'h00001234, 3'b000, 2'd0);
        step();
        idle_in();
        chk("rd0_store", {31'd0, rf_store}, 32'd0);
        chk("rd0_retire", {31'd0, w_retire}, 32'd1);
        step();
        chk("rd0_retire_after", {31'd0, w_retire}, 32'd0);

        // Reset abandons an outstanding load
        issue(1'b1, 1'b1, 5'd11, 32'h0, 3'b010, 2'd0);
        step();
        idle_in();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        dm_done = 1'b1;
        dm_data = 32'h55AA55AA;
        #1;
        chk("abandon_stall", {31'd0, w_stall}, 32'd0);
        step();
        idle_in();
        chk_quiet("abandon");

        // Back-to-back: ALU op accepted on the load-done edge
        issue(1'b1, 1'b1, 5'd12, 32'h0, 3'b010, 2'd0);
        step();
        issue(1'b0, 1'b1, 5'd3, 32'h00000011, 3'b000, 2'd0);
        dm_done = 1'b1;
        dm_data = 32'hCAFEF00D;
        #1;
        chk("b2b_stall", {31'd0, w_stall}, 32'd0);
        step();
        idle_in();
        chk_wr("b2b_load", 5'd12, 32'hCAFEF00D);
        step();
        chk_wr("b2b_alu", 5'd3, 32'h00000011);
        step();
        chk_quiet("b2b_after");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
